// File: rtl/mnist_pkg.sv
// Shared constants, state encoding and output decode for the MNIST 784-32-10 sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   IMG_SIZE / HID_SIZE / OUT_SIZE  network dimensions
//   RELU_CYCLES                     default ReLU hold length
//   LSEL_*                          layer_sel encodings
//   state_t                         sequencer state enum (3-bit)
//   ctrl_t / decode_ctrl()          per-state strobe decode
package mnist_pkg;

  // Network dimensions.
  localparam int IMG_SIZE    = 784;
  localparam int HID_SIZE    = 32;
  localparam int OUT_SIZE    = 10;
  localparam int RELU_CYCLES = 2;

  // Counter widths. Both are sized to hold IMG_SIZE-1 (783).
  localparam int ROW_W = 10;
  localparam int CNT_W = 10;

  // layer_sel encodings seen by the memory controller.
  localparam logic [1:0] LSEL_NONE = 2'd0;  // IDLE / LOAD / DONE
  localparam logic [1:0] LSEL_L1   = 2'd1;  // layer-1 sweep
  localparam logic [1:0] LSEL_L2   = 2'd2;  // ReLU and layer-2 sweep
  localparam logic [1:0] LSEL_MAX  = 2'd3;  // argmax capture

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_L1   = 3'd2,
    ST_RELU = 3'd3,
    ST_L2   = 3'd4,
    ST_MAX  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  // All single-cycle control outputs, registered together as one word.
  typedef struct packed {
    logic       done;
    logic       busy;
    logic [1:0] layer_sel;
    logic       mac_en_l1;
    logic       mac_clr_l1;
    logic       mac_en_l2;
    logic       mac_clr_l2;
    logic       load_img;
    logic       comp_l1;
    logic       apply_relu;
    logic       comp_l2;
    logic       find_max;
  } ctrl_t;

  // Pure decode of a state into its strobes. Only one phase strobe is ever
  // set per state, and the clears are tied to LOAD while the enables are
  // tied to the compute states, so mac_en/mac_clr can never overlap.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_LOAD: begin
        c.busy       = 1'b1;
        c.layer_sel  = LSEL_NONE;
        c.load_img   = 1'b1;
        c.mac_clr_l1 = 1'b1;
        c.mac_clr_l2 = 1'b1;
      end
      ST_L1: begin
        c.busy      = 1'b1;
        c.layer_sel = LSEL_L1;
        c.comp_l1   = 1'b1;
        c.mac_en_l1 = 1'b1;
      end
      ST_RELU: begin
        c.busy       = 1'b1;
        c.layer_sel  = LSEL_L2;
        c.apply_relu = 1'b1;
      end
      ST_L2: begin
        c.busy      = 1'b1;
        c.layer_sel = LSEL_L2;
        c.comp_l2   = 1'b1;
        c.mac_en_l2 = 1'b1;
      end
      ST_MAX: begin
        c.busy      = 1'b1;
        c.layer_sel = LSEL_MAX;
        c.find_max  = 1'b1;
      end
      ST_DONE: begin
        c.done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mnist_edge_det.sv
// Rising-edge detector for the level-sensitive start input.
// Latency: rise is combinational from sig against a 1-cycle delayed copy.
// Backpressure: none; the consumer decides whether to act on rise.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset (clears the history bit)
//   sig   level input being watched
//   rise  sig & ~sig_q
module mnist_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // History clears to 0, so a sig already high when reset releases is
  // reported as an edge on the first clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/mnist_ctrl_fsm.sv
// Central sequencer: LOAD -> L1 sweep -> RELU -> L2 sweep -> MAX -> DONE.
// Latency: LOAD one cycle after the start edge is sampled; DONE 820 cycles after LOAD.
// Backpressure: none; start edges arriving while busy are dropped.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   start           level input; only a rising edge launches an inference
//   done, busy      status (DONE state / LOAD..MAX)
//   layer_sel       0 idle/load/done, 1 L1, 2 RELU/L2, 3 MAX
//   row_idx         weight row of the current sweep, 0 otherwise
//   mac_en_l*/mac_clr_l*  accumulator enable/clear strobes
//   load_img, comp_l1, apply_relu, comp_l2, find_max  one-hot phase strobes
//   cycle_cnt       busy-cycle counter, saturating, held while idle/done
module mnist_ctrl_fsm #(
  parameter int IMG_SIZE    = mnist_pkg::IMG_SIZE,
  parameter int HID_SIZE    = mnist_pkg::HID_SIZE,
  parameter int RELU_CYCLES = mnist_pkg::RELU_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        done,
  output logic        busy,
  output logic [1:0]  layer_sel,
  output logic [9:0]  row_idx,
  output logic        mac_en_l1,
  output logic        mac_clr_l1,
  output logic        mac_en_l2,
  output logic        mac_clr_l2,
  output logic        load_img,
  output logic        comp_l1,
  output logic        apply_relu,
  output logic        comp_l2,
  output logic        find_max,
  output logic [9:0]  cycle_cnt
);

  import mnist_pkg::*;

  // Phase counter only has to span the ReLU hold.
  localparam int PH_W = (RELU_CYCLES > 1) ? $clog2(RELU_CYCLES) : 1;

  localparam logic [ROW_W-1:0] ROW_L1_LAST = ROW_W'(IMG_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_L2_LAST = ROW_W'(HID_SIZE - 1);
  localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(RELU_CYCLES - 1);

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ctrl_t             ctrl_q;

  logic start_rise;
  logic launch;

  mnist_edge_det u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (start),
    .rise (start_rise)
  );

  // busy comes from the registered decode, so it reflects the state
  // currently being executed.
  assign launch = start_rise & ~ctrl_q.busy;

  // Next state and next counter values.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (launch) begin
          state_d = ST_LOAD;
          row_d   = '0;
        end
      end
      ST_LOAD: begin
        state_d = ST_L1;
        row_d   = '0;
      end
      ST_L1: begin
        if (row_q == ROW_L1_LAST) begin
          state_d = ST_RELU;
          row_d   = '0;
          ph_d    = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      ST_RELU: begin
        // row stays 0 here; the phase counter times the hold instead.
        if (ph_q == PH_LAST) begin
          state_d = ST_L2;
          row_d   = '0;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_L2: begin
        if (row_q == ROW_L2_LAST) begin
          state_d = ST_MAX;
          row_d   = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      ST_MAX: begin
        state_d = ST_DONE;
        row_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        row_d   = '0;
        ph_d    = '0;
      end
    endcase

    // cycle_cnt is 0 in the LOAD cycle itself and counts every cycle after
    // while the current state is busy; the MAX->DONE step therefore lands
    // on 1 + IMG_SIZE + RELU_CYCLES + HID_SIZE + 1.
    if (state_d == ST_LOAD) begin
      cnt_d = '0;
    end else if (ctrl_q.busy && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Single state register. Outputs are decoded from the next state and
  // registered alongside it, so they are valid in the same cycle as the
  // state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      ph_q    <= '0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= decode_ctrl(state_d);
    end
  end

  assign done       = ctrl_q.done;
  assign busy       = ctrl_q.busy;
  assign layer_sel  = ctrl_q.layer_sel;
  assign mac_en_l1  = ctrl_q.mac_en_l1;
  assign mac_clr_l1 = ctrl_q.mac_clr_l1;
  assign mac_en_l2  = ctrl_q.mac_en_l2;
  assign mac_clr_l2 = ctrl_q.mac_clr_l2;
  assign load_img   = ctrl_q.load_img;
  assign comp_l1    = ctrl_q.comp_l1;
  assign apply_relu = ctrl_q.apply_relu;
  assign comp_l2    = ctrl_q.comp_l2;
  assign find_max   = ctrl_q.find_max;
  assign row_idx    = row_q;
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_mnist_ctrl_fsm.sv
// Directed bench for the MNIST sequencer.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mnist_ctrl_fsm;

  localparam int EXP_L1   = 784;
  localparam int EXP_RELU = 2;
  localparam int EXP_L2   = 32;
  localparam int EXP_CNT  = 1 + EXP_L1 + EXP_RELU + EXP_L2 + 1;  // 820

  logic       clk;
  logic       rst;
  logic       start;
  logic       done;
  logic       busy;
  logic [1:0] layer_sel;
  logic [9:0] row_idx;
  logic       mac_en_l1;
  logic       mac_clr_l1;
  logic       mac_en_l2;
  logic       mac_clr_l2;
  logic       load_img;
  logic       comp_l1;
  logic       apply_relu;
  logic       comp_l2;
  logic       find_max;
  logic [9:0] cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int mon_err  = 0;

  mnist_ctrl_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .layer_sel  (layer_sel),
    .row_idx    (row_idx),
    .mac_en_l1  (mac_en_l1),
    .mac_clr_l1 (mac_clr_l1),
    .mac_en_l2  (mac_en_l2),
    .mac_clr_l2 (mac_clr_l2),
    .load_img   (load_img),
    .comp_l1    (comp_l1),
    .apply_relu (apply_relu),
    .comp_l2    (comp_l2),
    .find_max   (find_max),
    .cycle_cnt  (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Everything quiet: no strobes, no status, row 0, counter at exp_cnt.
  task automatic check_quiet(input string tag, input int exp_cnt);
    check({tag, " strobes"}, {done, busy, mac_en_l1, mac_clr_l1, mac_en_l2, mac_clr_l2,
                              load_img, comp_l1, apply_relu, comp_l2, find_max}, 0);
    check({tag, " layer_sel"}, layer_sel, 0);
    check({tag, " row_idx"}, row_idx, 0);
    check({tag, " cycle_cnt"}, cycle_cnt, exp_cnt);
  endtask

  // Follows one inference from LOAD to DONE, counting phase lengths and
  // checking the row sequence of both sweeps.
  task automatic run_seq(input string tag);
    int i, t, n_load, n_l1, n_relu, n_l2, n_max, row_bad;
    i = 0;
    while (!load_img && i < 20) begin
      @(negedge clk);
      i++;
    end
    check({tag, " load_seen"}, load_img, 1);
    check({tag, " cnt_at_load"}, cycle_cnt, 0);
    check({tag, " done_at_load"}, done, 0);
    if (!load_img) return;
    t = 0; n_load = 1; n_l1 = 0; n_relu = 0; n_l2 = 0; n_max = 0; row_bad = 0;
    while (!done && t < 1000) begin
      @(negedge clk);
      t++;
      if (load_img) n_load++;
      if (comp_l1) begin
        if (row_idx != 10'(n_l1)) row_bad++;
        n_l1++;
      end
      if (apply_relu) n_relu++;
      if (comp_l2) begin
        if (row_idx != 10'(n_l2)) row_bad++;
        n_l2++;
      end
      if (find_max) n_max++;
    end
    check({tag, " done_seen"}, done, 1);
    check({tag, " latency"}, t, EXP_CNT);
    check({tag, " n_load"}, n_load, 1);
    check({tag, " n_l1"}, n_l1, EXP_L1);
    check({tag, " n_relu"}, n_relu, EXP_RELU);
    check({tag, " n_l2"}, n_l2, EXP_L2);
    check({tag, " n_max"}, n_max, 1);
    check({tag, " row_seq_errs"}, row_bad, 0);
    check({tag, " cnt_at_done"}, cycle_cnt, EXP_CNT);
    check({tag, " busy_at_done"}, busy, 0);
    check({tag, " lsel_at_done"}, layer_sel, 0);
  endtask

  // Per-cycle invariants, tallied and compared at the end of the run.
  always @(negedge clk) begin
    if (rst) begin
      logic [1:0] exp_ls;
      logic       any_phase;
      any_phase = load_img | comp_l1 | apply_relu | comp_l2 | find_max;
      exp_ls = load_img ? 2'd0 : comp_l1 ? 2'd1 : (apply_relu | comp_l2) ? 2'd2 :
               find_max ? 2'd3 : 2'd0;
      if ($countones({load_img, comp_l1, apply_relu, comp_l2, find_max}) > 1) mon_err++;
      if ((mac_en_l1 | mac_en_l2) & (mac_clr_l1 | mac_clr_l2)) mon_err++;
      if (busy != any_phase) mon_err++;
      if (layer_sel != exp_ls) mon_err++;
      if (mac_en_l1 != comp_l1 || mac_en_l2 != comp_l2) mon_err++;
      if (mac_clr_l1 != load_img || mac_clr_l2 != load_img) mon_err++;
      if (done & busy) mon_err++;
      if (row_idx != 10'd0 && !(comp_l1 | comp_l2)) mon_err++;
      if (row_idx > 10'd783) mon_err++;
    end
  end

  initial begin
    int n_ld;
    int i;
    bit found;

    // Reset state.
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("in_reset", 0);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("idle", 0);

    // Single start pulse.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_seq("single");
    repeat (5) @(negedge clk);
    check("single done_hold", done, 1);
    check("single cnt_hold", cycle_cnt, EXP_CNT);

    // Start held high for 2000 cycles: exactly one inference.
    start = 1'b1;
    run_seq("held");
    n_ld = 0;
    for (int k = 0; k < 1150; k++) begin
      @(negedge clk);
      if (load_img) n_ld++;
    end
    check("held no_relaunch", n_ld, 0);
    check("held done", done, 1);
    check("held cnt", cycle_cnt, EXP_CNT);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("low done", done, 1);

    // New edge from DONE: done drops as LOAD begins, counter restarts.
    start = 1'b1;
    run_seq("from_done");

    // Extra edge in the middle of L1 must be ignored.
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    fork
      run_seq("glitch");
      begin
        repeat (400) @(negedge clk);
        check("glitch in_l1", comp_l1, 1);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join

    // Asynchronous reset at L2 row 10.
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    i = 0;
    while (!found && i < 1000) begin
      if (comp_l2 && row_idx == 10'd10) found = 1;
      else begin
        @(negedge clk);
        i++;
      end
    end
    check("l2_row10 reached", found, 1);
    #2 rst = 1'b0;
    #1 check_quiet("async_rst", 0);
    start = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("rst_held", 0);
    // start already high at release counts as an edge.
    rst = 1'b1;
    run_seq("after_rst");

    check("monitor invariants", mon_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
